rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter.sv | 139 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Two-requester round-robin arbiter streaming ROM bursts back to the winning port.
// Response latency 2 cycles from handshake; no response backpressure, request side stalls (req_ready=0) during BURST.
module rom_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              iss_vld_q, iss_vld_d;
    logic              iss_owner_q, iss_owner_d;
    logic              iss_last_q, iss_last_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;

    logic [1:0]        grant;
    logic              win;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant = 2'b00;
        if (!rst && state_q == S_IDLE) begin
            if (req_valid == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign win      = grant[1];
    assign sel_addr = win ? req_addr1 : req_addr0;
    assign sel_len  = win ? req_len1 : req_len0;

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        remaining_d  = remaining_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        iss_vld_d    = 1'b0;
        iss_owner_d  = iss_owner_q;
        iss_last_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (grant != 2'b00) begin
                rom_addr_d   = sel_addr;
                remaining_d  = sel_len;
                last_grant_d = win;
                owner_d      = win;
                iss_vld_d    = 1'b1;
                iss_owner_d  = win;
                iss_last_d   = (sel_len == '0);
                state_d      = (sel_len == '0) ? S_IDLE : S_BURST;
            end
        end else begin
            rom_addr_d  = rom_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - LEN_W'(1);
            iss_vld_d   = 1'b1;
            iss_owner_d = owner_q;
            iss_last_d  = (remaining_q == LEN_W'(1));
            if (remaining_q == LEN_W'(1)) begin
                state_d = S_IDLE;
            end
        end
    end

    // rom_data reflects the address issued on the previous edge; capture it here.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        if (iss_vld_q) begin
            rsp_valid_d = iss_owner_q ? 2'b10 : 2'b01;
            rsp_last_d  = iss_last_q;
            rsp_data_d  = rom_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            remaining_q  <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            iss_vld_q    <= 1'b0;
            iss_owner_q  <= 1'b0;
            iss_last_q   <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            remaining_q  <= remaining_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            iss_vld_q    <= iss_vld_d;
            iss_owner_q  <= iss_owner_d;
            iss_last_q   <= iss_last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    assign req_ready = grant;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == S_BURST) || iss_vld_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios checked by a per-cycle schedule model plus literal spot checks.
module tb_rom_port_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [9:0] req_addr0, req_addr1;
    logic [1:0] req_len0, req_len1;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    rom_port_arbiter #(.ADDR_W(10), .DATA_W(8), .LEN_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_len0  (req_len0),
        .req_len1  (req_len1),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy)
    );

    function automatic logic [7:0] rom_f(input logic [9:0] a);
        if (a == 10'h005) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    assign rom_data = rom_f(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: each handshake writes what must happen in future cycles into per-cycle tables.
    localparam int N = 256;
    bit         av[N];
    logic [9:0] aa[N];
    bit         rv[N];
    bit         ro[N];
    logic [9:0] ra[N];
    bit         rl[N];
    bit         bz[N];
    int         n = 0;
    int         blk = -1;
    bit         lg = 1'b1;
    logic [9:0] hold_a = '0;
    logic [7:0] hold_d = '0;

    always @(negedge clk) begin : model
        logic [1:0] e_ready, e_valid;
        logic       e_last;
        logic       w;
        int         len;
        logic [9:0] a0;
        if (n + 8 >= N) begin
            failures++;
            $display("FAIL model_table_overflow cycle %0d", n);
            $fatal(1, "model table exhausted");
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                av[i] = 0; rv[i] = 0; bz[i] = 0; rl[i] = 0;
            end
            lg = 1'b1; blk = -1; hold_a = '0; hold_d = '0;
            chk("rst_ready", {30'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
            chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
            chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end else begin
            if (av[n]) hold_a = aa[n];
            e_valid = 2'b00;
            e_last  = 1'b0;
            if (rv[n]) begin
                e_valid = ro[n] ? 2'b10 : 2'b01;
                e_last  = rl[n];
                hold_d  = rom_f(ra[n]);
            end
            e_ready = 2'b00;
            if (n > blk && req_valid != 2'b00) begin
                w = (req_valid == 2'b11) ? ~lg : req_valid[1];
                e_ready = w ? 2'b10 : 2'b01;
            end
            chk("rom_addr", {22'd0, rom_addr}, {22'd0, hold_a});
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e_valid});
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, e_last});
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, hold_d});
            chk("busy", {31'd0, busy}, {31'd0, bz[n]});
            chk("req_ready", {30'd0, req_ready}, {30'd0, e_ready});
            if (e_ready != 2'b00) begin
                len = w ? int'(req_len1) : int'(req_len0);
                a0  = w ? req_addr1 : req_addr0;
                lg  = w;
                blk = n + len;
                for (int k = 0; k <= len; k++) begin
                    av[n+1+k] = 1; aa[n+1+k] = a0 + 10'(k);
                    rv[n+2+k] = 1; ro[n+2+k] = w; ra[n+2+k] = a0 + 10'(k);
                    rl[n+2+k] = (k == len);
                    bz[n+1+k] = 1;
                end
            end
        end
        n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Single beat from requester 0
        tick(); req_addr0 = 10'h005; req_len0 = 2'd0; req_valid = 2'b01;
        #1 chk("t1_ready", {30'd0, req_ready}, 32'h1);
        tick(); req_valid = 2'b00;
        tick(); #1;
        chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("t1_rsp_data", {24'd0, rsp_data}, 32'hA5);
        chk("t1_rsp_last", {31'd0, rsp_last}, 32'h1);
        tick(); #1;
        chk("t1_rsp_valid_drop", {30'd0, rsp_valid}, 32'h0);
        chk("t1_rsp_data_hold", {24'd0, rsp_data}, 32'hA5);

        // Wrapping burst from requester 1, inputs churn during BURST
        tick(); req_addr1 = 10'h3FE; req_len1 = 2'd3; req_valid = 2'b10;
        #1 chk("t2_ready", {30'd0, req_ready}, 32'h2);
        tick(); req_valid = 2'b11; req_addr0 = 10'h007; req_addr1 = 10'h100; req_len1 = 2'd0;
        #1 chk("t2_ready_burst", {30'd0, req_ready}, 32'h0);
        chk("t2_addr0", {22'd0, rom_addr}, 32'h3FE);
        tick(); #1 chk("t2_addr1", {22'd0, rom_addr}, 32'h3FF);
        tick(); req_valid = 2'b00;
        #1 chk("t2_addr2", {22'd0, rom_addr}, 32'h000);
        tick(); #1 chk("t2_addr3", {22'd0, rom_addr}, 32'h001);
        tick(); #1;
        chk("t2_last_valid", {30'd0, rsp_valid}, 32'h2);
        chk("t2_last", {31'd0, rsp_last}, 32'h1);
        tick(); #1 chk("t2_idle_busy", {31'd0, busy}, 32'h0);

        // Tie alternation after reset
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req_addr0 = 10'h020; req_addr1 = 10'h030; req_len0 = 2'd0; req_len1 = 2'd0;
        req_valid = 2'b11;
        #1 chk("t3_g0", {30'd0, req_ready}, 32'h1);
        tick(); #1 chk("t3_g1", {30'd0, req_ready}, 32'h2);
        tick(); #1 chk("t3_g2", {30'd0, req_ready}, 32'h1);
        tick(); #1 chk("t3_g3", {30'd0, req_ready}, 32'h2);
        tick(); req_valid = 2'b00;
        repeat (2) tick();

        // Back-to-back: req0 len 1 then held req1 len 0
        tick(); req_addr0 = 10'h010; req_len0 = 2'd1; req_addr1 = 10'h020; req_len1 = 2'd0;
        req_valid = 2'b01;
        #1 chk("t4_g0", {30'd0, req_ready}, 32'h1);
        tick(); req_valid = 2'b10;
        #1 chk("t4_burst_ready", {30'd0, req_ready}, 32'h0);
        tick(); #1 chk("t4_g1", {30'd0, req_ready}, 32'h2);
        tick(); req_valid = 2'b00;
        tick(); #1;
        chk("t4_third_beat", {30'd0, rsp_valid}, 32'h2);
        chk("t4_third_last", {31'd0, rsp_last}, 32'h1);
        repeat (2) tick();

        // Reset during a burst
        tick(); req_addr0 = 10'h040; req_len0 = 2'd3; req_valid = 2'b01;
        #1 chk("t5_g0", {30'd0, req_ready}, 32'h1);
        tick(); req_valid = 2'b00; rst = 1'b1;
        #1;
        chk("t5_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        chk("t5_rsp_data", {24'd0, rsp_data}, 32'h0);
        chk("t5_rom_addr", {22'd0, rom_addr}, 32'h0);
        chk("t5_busy", {31'd0, busy}, 32'h0);
        chk("t5_ready", {30'd0, req_ready}, 32'h0);
        tick(); rst = 1'b0;
        repeat (6) tick();
        req_addr0 = 10'h011; req_addr1 = 10'h012; req_len0 = 2'd0; req_len1 = 2'd0;
        req_valid = 2'b11;
        #1 chk("t5_tie_after_rst", {30'd0, req_ready}, 32'h1);
        tick(); req_valid = 2'b00;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
